// File: rtl/dram_req_queue.sv
// dram_req_queue: valid/ready request FIFO that splits the head address into bank/row/col for the DRAM FSM
module dram_req_queue #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int DEPTH           = 4,
  localparam int BANK_W = $clog2(NUMBER_OF_BANKS),
  localparam int ROW_W  = $clog2(NUMBER_OF_ROWS),
  localparam int COL_W  = $clog2(NUMBER_OF_COLS),
  localparam int ADDR_W = BANK_W + ROW_W + COL_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [9:0]        req_len,
  input  logic              refresh_flag,
  input  logic              address_buff_en,
  output logic              addr_val,
  output logic [BANK_W-1:0] bank_id,
  output logic [ROW_W-1:0]  row_id,
  output logic [COL_W-1:0]  col_id,
  output logic [9:0]        offset,
  output logic [CNT_W-1:0]  q_count,
  output logic              underflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [ADDR_W+9:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ADDR_W+9:0] head;
  logic empty, push, pop;
  assign empty     = (count == '0);
  assign req_ready = (count != CNT_W'(DEPTH));
  assign push      = req_valid & req_ready;
  assign pop       = address_buff_en & ~empty;
  assign head      = empty ? '0 : mem[rd_ptr];
  assign addr_val  = ~empty & ~refresh_flag;
  assign bank_id   = head[ADDR_W+9-:BANK_W];
  assign row_id    = head[COL_W+10+:ROW_W];
  assign col_id    = head[10+:COL_W];
  assign offset    = head[9:0];
  assign q_count   = count;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop) count <= count + CNT_W'(1);
      else if (pop & ~push) count <= count - CNT_W'(1);
      if (address_buff_en & empty) underflow_err <= 1'b1;
    end
  end
  // storage is deliberately left unreset; count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_addr, req_len};
  end
endmodule

// File: tb/tb_dram_req_queue.sv
// tb_dram_req_queue: directed stimulus, queue-based reference model checked every cycle, plus literal pins
module tb_dram_req_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst_b = 0, req_valid = 0, refresh_flag = 0, address_buff_en = 0;
  logic [12:0] req_addr = 0;
  logic [9:0] req_len = 0;
  logic req_ready, addr_val, underflow_err;
  logic [2:0] bank_id, col_id, q_count;
  logic [6:0] row_id;
  logic [9:0] offset;
  int n_cmp = 0, n_bad = 0;
  int mq[$];
  bit m_uf;

  dram_req_queue dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .refresh_flag(refresh_flag),
    .address_buff_en(address_buff_en), .addr_val(addr_val), .bank_id(bank_id),
    .row_id(row_id), .col_id(col_id), .offset(offset), .q_count(q_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // reference: entries stored as addr*1024+len; fields recovered by division
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mq.delete();
      m_uf = 0;
    end else begin
      bit p, q;
      p = req_valid && mq.size() < DEPTH;
      q = address_buff_en && mq.size() != 0;
      if (address_buff_en && mq.size() == 0) m_uf = 1;
      if (q) void'(mq.pop_front());
      if (p) mq.push_back(int'(req_addr) * 1024 + int'(req_len));
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      int a, l;
      a = mq.size() ? mq[0] / 1024 : 0;
      l = mq.size() ? mq[0] % 1024 : 0;
      chk("m_addr_val", addr_val, (mq.size() != 0 && !refresh_flag) ? 1 : 0);
      chk("m_req_ready", req_ready, mq.size() < DEPTH ? 1 : 0);
      chk("m_q_count", q_count, mq.size());
      chk("m_bank", bank_id, a / 1024);
      chk("m_row", row_id, (a / 8) % 128);
      chk("m_col", col_id, a % 8);
      chk("m_offset", offset, l);
      chk("m_underflow", underflow_err, m_uf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(logic [12:0] a, logic [9:0] l);
    req_valid = 1; req_addr = a; req_len = l;
    tick();
    req_valid = 0;
  endtask

  initial begin
    repeat (2) tick();
    rst_b = 1;
    tick();
    chk("rst_q_count", q_count, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_addr_val", addr_val, 0);
    chk("rst_underflow", underflow_err, 0);
    // single push and field split
    push1(13'h1A5B, 10'd5);
    chk("single_val", addr_val, 1);
    chk("single_bank", bank_id, 6);
    chk("single_row", row_id, 32'h4B);
    chk("single_col", col_id, 3);
    chk("single_off", offset, 5);
    address_buff_en = 1; tick(); address_buff_en = 0;
    chk("single_pop_cnt", q_count, 0);
    // fill beyond depth
    req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 13'(i * 13'h0357 + 1); req_len = 10'(i + 1);
      tick();
    end
    chk("fill_ready", req_ready, 0);
    chk("fill_cnt", q_count, 4);
    req_addr = 13'h1FFF; req_len = 10'd5;
    tick();
    chk("fill_held_cnt", q_count, 4);
    chk("fill_head_off", offset, 1);
    address_buff_en = 1; tick(); address_buff_en = 0;
    chk("fill_pop_cnt", q_count, 3);
    chk("fill_pop_off", offset, 2);
    tick();
    req_valid = 0;
    chk("fill_5th_cnt", q_count, 4);
    address_buff_en = 1;
    repeat (4) tick();
    address_buff_en = 0;
    chk("fill_drain_cnt", q_count, 0);
    // concurrent push/pop across pointer wrap
    push1(13'h0010, 10'd100);
    push1(13'h0020, 10'd101);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; address_buff_en = 1;
      req_addr = 13'(13'h0400 * (i % 8) + i); req_len = 10'(200 + i);
      tick();
      chk("conc_cnt", q_count, 2);
    end
    req_valid = 0;
    chk("conc_head_off", offset, 208);
    repeat (2) tick();
    address_buff_en = 0;
    chk("conc_drain_cnt", q_count, 0);
    // refresh masking
    push1(13'h0ABC, 10'd0);
    refresh_flag = 1;
    tick();
    chk("ref_masked", addr_val, 0);
    chk("ref_bank", bank_id, 2);
    chk("ref_col", col_id, 4);
    refresh_flag = 0;
    #1;
    chk("ref_unmasked", addr_val, 1);
    chk("ref_row", row_id, 32'h57);
    address_buff_en = 1; refresh_flag = 1; tick();
    address_buff_en = 0; refresh_flag = 0;
    chk("ref_pop_cnt", q_count, 0);
    // underflow
    address_buff_en = 1; tick(); address_buff_en = 0;
    chk("uf_flag", underflow_err, 1);
    chk("uf_cnt", q_count, 0);
    repeat (3) tick();
    chk("uf_sticky", underflow_err, 1);
    // reset mid-burst
    push1(13'h0001, 10'd1);
    push1(13'h0002, 10'd2);
    push1(13'h0003, 10'd3);
    req_valid = 1; req_addr = 13'h0004; req_len = 10'd4;
    #2;
    rst_b = 0;
    #1;
    chk("mrst_val", addr_val, 0);
    chk("mrst_cnt", q_count, 0);
    chk("mrst_ready", req_ready, 1);
    chk("mrst_uf", underflow_err, 0);
    req_valid = 0;
    tick();
    rst_b = 1;
    tick();
    chk("mrst_after_cnt", q_count, 0);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
